// File: rtl/sha2_host_ctrl_pkg.sv
// Shared definitions for the SHA-2 host controller: engine control codes and FSM state encoding.
package sha2_host_ctrl_pkg;

  localparam logic [3:0] CTRL_IDLE  = 4'b0000;
  localparam logic [3:0] CTRL_RST   = 4'b0001;
  localparam logic [3:0] CTRL_LOAD  = 4'b0010;
  localparam logic [3:0] CTRL_START = 4'b0100;

  localparam int BLOCK_WORDS = 16;
  localparam int ADDR_W      = 5;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_REARM,
    ST_RADDR,
    ST_RDATA,
    ST_ERR
  } state_t;

  // Engine control word seen by the core in each state; REARM reuses LOAD so no core reset occurs between blocks.
  function automatic logic [3:0] ctrl_code(input state_t s);
    logic [3:0] c;
    c = CTRL_IDLE;
    case (s)
      ST_INIT:  c = CTRL_RST;
      ST_LOAD:  c = CTRL_LOAD;
      ST_START: c = CTRL_START;
      ST_REARM: c = CTRL_LOAD;
      ST_ERR:   c = CTRL_RST;
      default:  c = CTRL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sha2_host_ctrl.sv
// Host-side sequencer for a SHA-2 core: streams 16-word blocks into the engine,
// starts each block, waits for completion and streams the digest words back out.
module sha2_host_ctrl
  import sha2_host_ctrl_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int OUT_WORDS = 8,
  parameter int TIMEOUT   = 1023
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WIDTH-1:0]  s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WIDTH-1:0]  m_data,
  output logic              m_last,
  output logic [3:0]        o_control,
  output logic [ADDR_W-1:0] o_add,
  output logic [WIDTH-1:0]  o_data,
  input  logic [WIDTH-1:0]  i_data_out,
  input  logic              i_end_op,
  output logic              o_busy,
  output logic              o_error
);

  localparam int TC_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(OUT_WORDS - 1);
  localparam logic [TC_W-1:0]   TC_END = TC_W'(TIMEOUT - 1);

  state_t            state;
  logic [3:0]        wc;
  logic [ADDR_W-1:0] k;
  logic [TC_W-1:0]   tc;
  logic              bl;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
      wc    <= '0;
      k     <= '0;
      tc    <= '0;
      bl    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (s_valid) state <= ST_INIT;
        end
        ST_INIT: begin
          wc    <= '0;
          bl    <= 1'b0;
          state <= ST_LOAD;
        end
        // A message must end exactly on a block boundary; an early s_last is fatal.
        ST_LOAD: begin
          if (s_valid) begin
            wc <= wc + 4'd1;
            if (wc == 4'd15) begin
              bl    <= s_last;
              state <= ST_START;
            end else if (s_last) begin
              state <= ST_ERR;
            end
          end
        end
        ST_START: begin
          tc    <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          tc <= tc + TC_W'(1);
          if (i_end_op) begin
            k     <= '0;
            state <= bl ? ST_RADDR : ST_REARM;
          end else if (tc == TC_END) begin
            state <= ST_ERR;
          end
        end
        ST_REARM: begin
          wc    <= '0;
          state <= ST_LOAD;
        end
        ST_RADDR: begin
          state <= ST_RDATA;
        end
        ST_RDATA: begin
          if (m_ready) begin
            if (k == K_LAST) begin
              k     <= '0;
              state <= ST_IDLE;
            end else begin
              k     <= k + ADDR_W'(1);
              state <= ST_RADDR;
            end
          end
        end
        ST_ERR: begin
          state <= ST_ERR;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Engine read data arrives one cycle after o_add, so o_add is held through RDATA to keep m_data stable.
  assign o_control = ctrl_code(state);
  assign s_ready   = (state == ST_LOAD);
  assign o_data    = (state == ST_LOAD) ? s_data : '0;
  assign o_add     = (state == ST_LOAD) ? {1'b0, wc} :
                     ((state == ST_RADDR) || (state == ST_RDATA)) ? k : '0;
  assign m_valid   = (state == ST_RDATA);
  assign m_data    = (state == ST_RDATA) ? i_data_out : '0;
  assign m_last    = (state == ST_RDATA) && (k == K_LAST);
  assign o_busy    = (state != ST_IDLE) && (state != ST_ERR);
  assign o_error   = (state == ST_ERR);

endmodule

// File: tb/tb_sha2_host_ctrl.sv
// Directed testbench for sha2_host_ctrl with a small behavioural SHA engine stand-in.
module tb_sha2_host_ctrl;

  localparam int WIDTH     = 64;
  localparam int OUT_WORDS = 8;
  localparam int TIMEOUT   = 1023;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             s_valid, s_ready, s_last;
  logic [WIDTH-1:0] s_data;
  logic             m_valid, m_ready, m_last;
  logic [WIDTH-1:0] m_data;
  logic [3:0]       o_control;
  logic [4:0]       o_add;
  logic [WIDTH-1:0] o_data;
  logic [WIDTH-1:0] i_data_out;
  logic             i_end_op;
  logic             o_busy, o_error;

  int tests = 0;
  int errs  = 0;

  always #5 i_clk = ~i_clk;

  sha2_host_ctrl #(.WIDTH(WIDTH), .OUT_WORDS(OUT_WORDS), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .o_control(o_control), .o_add(o_add), .o_data(o_data),
    .i_data_out(i_data_out), .i_end_op(i_end_op),
    .o_busy(o_busy), .o_error(o_error)
  );

  function automatic logic [63:0] iv(input int j);
    return 64'(j + 1) * 64'h0123_4567_89AB_CDEF;
  endfunction

  // Engine stand-in: block mixes halves into an 8-word state, finishes 4 cycles after start.
  logic [63:0] eng_mem [16];
  logic [63:0] eng_h   [8];
  int          eng_cnt  = 0;
  logic        eng_hang = 1'b0;

  always @(posedge i_clk) begin
    i_end_op <= 1'b0;
    if (o_control == 4'b0010) eng_mem[o_add[3:0]] <= o_data;
    if (o_control == 4'b0001)
      for (int j = 0; j < 8; j++) eng_h[j] <= iv(j);
    if (o_control == 4'b0100) begin
      for (int j = 0; j < 8; j++) eng_h[j] <= (eng_h[j] ^ eng_mem[j]) + eng_mem[j+8];
      eng_cnt <= 4;
    end else if (eng_cnt != 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1 && !eng_hang) i_end_op <= 1'b1;
    end
    i_data_out <= eng_h[o_add[2:0]];
  end

  int          n_init  = 0;
  int          n_start = 0;
  int          n_rearm = 0;
  logic [4:0]  wr_add_q [$];
  logic [63:0] wr_dat_q [$];

  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_control == 4'b0001 && !o_error) n_init++;
      if (o_control == 4'b0100) n_start++;
      if (o_control == 4'b0010 && !s_ready) n_rearm++;
      if (s_ready && s_valid) begin
        wr_add_q.push_back(o_add);
        wr_dat_q.push_back(o_data);
      end
    end
  end

  logic [63:0] msg   [32];
  logic [63:0] exp_d [8];

  task automatic make_msg(input int seed, input int n);
    for (int i = 0; i < n; i++)
      msg[i] = {16'hA5C3, 16'(seed), 16'(i * 7 + 3), 16'(seed * 31 + i)};
  endtask

  task automatic compute_expected(input int nwords);
    for (int j = 0; j < 8; j++) exp_d[j] = iv(j);
    for (int b = 0; b < nwords / 16; b++)
      for (int j = 0; j < 8; j++)
        exp_d[j] = (exp_d[j] ^ msg[b*16+j]) + msg[b*16+j+8];
  endtask

  task automatic send_words(input int n, input int last_idx, output int accepted);
    int guard;
    accepted = 0;
    guard = 0;
    while (accepted < n && guard < 300) begin
      s_valid = 1'b1;
      s_data  = msg[accepted];
      s_last  = (accepted == last_idx);
      @(negedge i_clk);
      if (s_ready) begin
        @(posedge i_clk); #1;
        accepted++;
      end else begin
        @(posedge i_clk); #1;
      end
      guard++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
  endtask

  task automatic collect_digest(input int stall_idx, input int stall_len);
    int got, cyc, stalled;
    got = 0; cyc = 0; stalled = 0;
    while (got < OUT_WORDS && cyc < 2000 && !o_error) begin
      @(negedge i_clk);
      cyc++;
      if (m_valid) begin
        tests++;
        if (m_data !== exp_d[got] || o_add !== 5'(got)) begin
          errs++;
          $display("[TB] FAIL digest_word%0d: got data %0h add %0d expected data %0h add %0d",
                   got, m_data, o_add, exp_d[got], got);
        end
        if (got == stall_idx && stalled < stall_len) begin
          m_ready = 1'b0;
          stalled++;
        end else begin
          m_ready = 1'b1;
          tests++;
          if (m_last !== (got == OUT_WORDS - 1)) begin
            errs++;
            $display("[TB] FAIL m_last_word%0d: got %b expected %b", got, m_last, got == OUT_WORDS - 1);
          end
          got++;
        end
      end else begin
        m_ready = 1'b1;
      end
    end
    m_ready = 1'b1;
    tests++;
    if (got != OUT_WORDS) begin
      errs++;
      $display("[TB] FAIL digest_count: got %0d expected %0d", got, OUT_WORDS);
    end
    @(posedge i_clk); #1;
    @(negedge i_clk);
    tests++;
    if (o_busy !== 1'b0 || m_valid !== 1'b0) begin
      errs++;
      $display("[TB] FAIL back_to_idle: got busy %b m_valid %b expected 0 0", o_busy, m_valid);
    end
  endtask

  task automatic check_writes(input int base, input int n);
    tests++;
    if (wr_add_q.size() - base != n) begin
      errs++;
      $display("[TB] FAIL write_count: got %0d expected %0d", wr_add_q.size() - base, n);
    end else begin
      for (int i = 0; i < n; i++) begin
        tests++;
        if (wr_add_q[base+i] !== 5'(i % 16) || wr_dat_q[base+i] !== msg[i]) begin
          errs++;
          $display("[TB] FAIL write%0d: got add %0d data %0h expected add %0d data %0h",
                   i, wr_add_q[base+i], wr_dat_q[base+i], i % 16, msg[i]);
        end
      end
    end
  endtask

  task automatic check_pulses(input string name, input int d_init, input int d_rearm, input int d_start,
                              input int e_init, input int e_rearm, input int e_start);
    tests++;
    if (d_init != e_init || d_rearm != e_rearm || d_start != e_start) begin
      errs++;
      $display("[TB] FAIL %s_pulses: got init %0d rearm %0d start %0d expected %0d %0d %0d",
               name, d_init, d_rearm, d_start, e_init, e_rearm, e_start);
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge i_clk);
    tests++;
    if ({o_control, o_add, s_ready, m_valid, m_last, o_busy, o_error} !== 14'd0 || o_data !== '0) begin
      errs++;
      $display("[TB] FAIL reset_outputs: got ctrl %b add %0d rdy %b mv %b ml %b busy %b err %b data %0h expected all 0",
               o_control, o_add, s_ready, m_valid, m_last, o_busy, o_error, o_data);
    end
    @(posedge i_clk); #1;
  endtask

  task automatic test_single_block();
    int acc, bw, bi, bs, br;
    make_msg(1, 16); compute_expected(16);
    bw = wr_add_q.size(); bi = n_init; bs = n_start; br = n_rearm;
    send_words(16, 15, acc);
    collect_digest(-1, 0);
    check_writes(bw, 16);
    check_pulses("single", n_init - bi, n_rearm - br, n_start - bs, 1, 0, 1);
  endtask

  task automatic test_two_blocks();
    int acc, bw, bi, bs, br;
    make_msg(2, 32); compute_expected(32);
    bw = wr_add_q.size(); bi = n_init; bs = n_start; br = n_rearm;
    send_words(32, 31, acc);
    collect_digest(-1, 0);
    check_writes(bw, 32);
    check_pulses("two_block", n_init - bi, n_rearm - br, n_start - bs, 1, 1, 2);
  endtask

  task automatic test_short_message();
    int acc, bs;
    make_msg(3, 10);
    bs = n_start;
    send_words(10, 9, acc);
    repeat (3) @(posedge i_clk);
    #1;
    @(negedge i_clk);
    tests++;
    if (o_error !== 1'b1 || s_ready !== 1'b0 || o_control !== 4'b0001 || o_busy !== 1'b0 || m_valid !== 1'b0) begin
      errs++;
      $display("[TB] FAIL short_msg_err: got err %b rdy %b ctrl %b busy %b mv %b expected 1 0 0001 0 0",
               o_error, s_ready, o_control, o_busy, m_valid);
    end
    check_pulses("short_msg", 0, 0, n_start - bs, 0, 0, 0);
    @(posedge i_clk); #1;
    do_reset();
    @(negedge i_clk);
    tests++;
    if (o_error !== 1'b0) begin
      errs++;
      $display("[TB] FAIL err_cleared: got %b expected 0", o_error);
    end
    @(posedge i_clk); #1;
  endtask

  task automatic test_timeout();
    int acc, waits, cyc;
    eng_hang = 1'b1;
    make_msg(4, 16);
    send_words(16, 15, acc);
    waits = 0; cyc = 0;
    while (!o_error && cyc < TIMEOUT + 200) begin
      @(negedge i_clk);
      cyc++;
      if (o_busy && o_control == 4'b0000) waits++;
    end
    tests++;
    if (o_error !== 1'b1 || waits != TIMEOUT) begin
      errs++;
      $display("[TB] FAIL timeout: got err %b after %0d wait cycles expected err 1 after %0d",
               o_error, waits, TIMEOUT);
    end
    eng_hang = 1'b0;
    @(posedge i_clk); #1;
    do_reset();
  endtask

  task automatic test_stall();
    int acc;
    make_msg(5, 16); compute_expected(16);
    send_words(16, 15, acc);
    collect_digest(3, 5);
  endtask

  task automatic test_reset_mid_load();
    int acc, bw, bi;
    make_msg(6, 16);
    send_words(7, -1, acc);
    s_valid = 1'b1; s_data = msg[7]; i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0; s_valid = 1'b0; s_data = '0;
    @(negedge i_clk);
    tests++;
    if ({o_control, o_add, s_ready, m_valid, m_last, o_busy, o_error} !== 14'd0 || o_data !== '0) begin
      errs++;
      $display("[TB] FAIL mid_load_reset: got ctrl %b add %0d rdy %b busy %b err %b expected all 0",
               o_control, o_add, s_ready, o_busy, o_error);
    end
    @(posedge i_clk); #1;
    make_msg(7, 16); compute_expected(16);
    bw = wr_add_q.size(); bi = n_init;
    send_words(16, 15, acc);
    collect_digest(-1, 0);
    check_writes(bw, 16);
    tests++;
    if (n_init - bi != 1) begin
      errs++;
      $display("[TB] FAIL after_reset_init: got %0d expected 1", n_init - bi);
    end
  endtask

  initial begin
    i_rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    test_reset();
    test_single_block();
    test_two_blocks();
    test_short_message();
    test_timeout();
    test_stall();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule

// File: doc/sha2_host_ctrl.md
SHA2_HOST_CTRL -- requirements
Module: sha2_host_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 64: engine word width in bits.
REQ-002 SHALL have parameter OUT_WORDS, default 8: number of digest words read back.
REQ-003 SHALL have parameter TIMEOUT, default 1023: maximum cycles to wait for o_end_op.
REQ-004 SHALL have port i_clk, input, 1: single clock; all logic rising-edge.
REQ-005 SHALL have port i_rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port s_valid / s_ready / s_data[WIDTH-1:0] / s_last, in/out/in/in: pre-padded message word stream; s_last marks final word.
REQ-007 SHALL have port m_valid / m_ready / m_data[WIDTH-1:0] / m_last, out/in/out/out: digest word stream, word 0 first.
REQ-008 SHALL have port o_control[3:0], output: engine control ([0] core reset, [1] load, [2] start, [3] always 0).
REQ-009 SHALL have port o_add[4:0] / o_data[WIDTH-1:0], output: engine write/read address and write data.
REQ-010 SHALL have port i_data_out[WIDTH-1:0] / i_end_op, input: engine read data (valid 1 cycle after o_add) and done flag.
REQ-011 SHALL have port o_busy / o_error, output: message in progress; sticky protocol/timeout error.

Function
REQ-012 SHALL implement states IDLE, INIT, LOAD, START, WAIT, REARM, RADDR, RDATA, ERR.
REQ-013 IDLE: o_control=0000, s_ready=0; on s_valid go INIT. No word is consumed in IDLE.
REQ-014 INIT: o_control=0001 for exactly 1 cycle, word counter wc=0, then LOAD.
REQ-015 LOAD: o_control=0010, s_ready=1, o_add=wc, o_data=s_data; on s_valid&s_ready wc increments, 4-bit.
REQ-016 LOAD: accepted word with wc=15 goes START. The block-last flag (BL) is set to s_last.
REQ-017 LOAD: s_last accepted with wc≠15 SHALL go ERR; the message SHALL be a multiple of 16 words.
REQ-018 START: o_control=0100 for exactly 1 cycle; timeout counter tc=0; then WAIT.
REQ-019 WAIT: o_control=0000; tc increments each cycle.
REQ-020 WAIT: on i_end_op with BL=0 go REARM; with BL=1 go RADDR with index k=0.
REQ-021 WAIT: tc reaching TIMEOUT without i_end_op SHALL go ERR.
REQ-022 REARM: o_control=0010 for 1 cycle (returns engine to load), wc=0, then LOAD; core reset SHALL NOT be asserted between blocks.
REQ-023 RADDR: o_control=0000, o_add=k for 1 cycle, then RDATA.
REQ-024 RDATA: o_add=k held, m_valid=1, m_data=i_data_out, m_last=(k==OUT_WORDS-1).
REQ-025 RDATA: m_data SHALL remain stable while m_valid&!m_ready.
REQ-026 RDATA: on accept with k<OUT_WORDS-1, k++ and go RADDR; with k==OUT_WORDS-1 go IDLE.
REQ-027 ERR: o_error=1, o_control=0001, s_ready=0, m_valid=0; ERR SHALL be left only by i_rst.
REQ-028 o_busy SHALL be 1 in every state except IDLE and ERR.
REQ-029 Throughput: one message word per cycle in LOAD; one digest word per 2 cycles.

Reset
REQ-030 i_rst SHALL force IDLE, synchronously, in any state including mid-block or mid-readout.
REQ-031 Reset values: o_control=0000, o_add=0, o_data=0, s_ready=0, m_valid=0, m_last=0, o_busy=0, o_error=0; wc, k, tc and BL = 0.
REQ-032 Reset SHALL take priority over all simultaneous handshakes.
REQ-033 A partly transferred digest SHALL be abandoned.

Structure
REQ-034 The shared package SHALL hold the control codes (CTRL_IDLE=0000, CTRL_RST=0001, CTRL_LOAD=0010, CTRL_START=0100) and the state encoding.
REQ-035 The block SHALL be a single module with no sub-modules; all outputs registered or decoded from the state register only.

Verification
REQ-036 Scenario: 16-word single block, s_last on word 15, m_ready=1. Required: INIT pulse 0001, 16 writes at o_add 0..15, one 0100 pulse, then 8 digest words matching the engine model, m_last on word 7.
REQ-037 Scenario: 32-word message (two blocks). Required: exactly one 0001 pulse, one REARM 0010 pulse between blocks, two 0100 pulses, then digest.
REQ-038 Scenario: s_last on word 9. Required: ERR, o_error=1, no 0100 pulse, s_ready=0.
REQ-039 Scenario: engine model never asserts i_end_op. Required: ERR after 1023 WAIT cycles.
REQ-040 Scenario: m_ready low for 5 cycles on digest word 3. Required: m_data and o_add stable for those 5 cycles, no word skipped or duplicated.
REQ-041 Scenario: i_rst during LOAD word 7. Required: IDLE next cycle, all outputs at reset values; a following full message hashes correctly.
